// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester ports and the data_mem side of
// the dmem_arbiter.
//   p0_* / p1_* : request (req/we/addr/wdata/funct3), combinational grant,
//                 registered response (rsp_valid/rdata/err)
//   mem_*       : address/data/size/write-enable to data_mem, comb read data back
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus memory)
interface dmem_arbiter_if;
    logic        p0_req, p0_we, p0_gnt, p0_rsp_valid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [2:0]  p0_funct3;
    logic        p1_req, p1_we, p1_gnt, p1_rsp_valid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [2:0]  p1_funct3;
    logic [31:0] mem_addr, mem_dataW, mem_dataR;
    logic [2:0]  mem_funct3;
    logic        mem_MemRW;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
        output p0_gnt, p0_rsp_valid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
        output p1_gnt, p1_rsp_valid, p1_rdata, p1_err,
        output mem_addr, mem_dataW, mem_funct3, mem_MemRW,
        input  mem_dataR
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
        input  p0_gnt, p0_rsp_valid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
        input  p1_gnt, p1_rsp_valid, p1_rdata, p1_err,
        input  mem_addr, mem_dataW, mem_funct3, mem_MemRW,
        output mem_dataR
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-ported
// data memory. Port 0 (load/store unit) has priority; port 1 (debug/DMA) is
// force-granted after STARVE_LIMIT consecutive denied request cycles.
// Illegal funct3 or misaligned accesses are screened and never reach memory.
// The granted port receives a one-cycle registered response the cycle after
// its grant.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave (both requester ports + data_mem side)
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CHECK_ALIGN  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        active;
    logic [3:0]  starve_cnt;
    logic        sel0, sel1, granted, illegal, go;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_f3;
    logic [1:0]  rsp_valid, err;
    logic [31:0] rdata0, rdata1;
    logic [31:0] rsp_data;

    // Port 1 wins only when port 0 is quiet or port 1 has waited long enough.
    assign sel1    = active && bus.p1_req && (!bus.p0_req || starve_cnt == LIMIT);
    assign sel0    = active && bus.p0_req && !sel1;
    assign granted = sel0 || sel1;

    always_comb begin
        sel_we    = bus.p0_we;
        sel_addr  = bus.p0_addr;
        sel_wdata = bus.p0_wdata;
        sel_f3    = bus.p0_funct3;
        if (sel1) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
            sel_f3    = bus.p1_funct3;
        end
    end

    // Legality: reserved size codes, unsigned codes used as stores, and
    // (optionally) natural alignment of halfword/word accesses.
    always_comb begin
        illegal = 1'b0;
        if (sel_f3 == 3'b011 || sel_f3 == 3'b110 || sel_f3 == 3'b111) illegal = 1'b1;
        if (sel_we && sel_f3[2]) illegal = 1'b1;
        if (CHECK_ALIGN != 0) begin
            if (sel_f3[1:0] == 2'b01 && sel_addr[0])           illegal = 1'b1;
            if (sel_f3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00) illegal = 1'b1;
        end
    end

    assign go = granted && !illegal;

    assign bus.mem_addr   = go ? sel_addr  : 32'h0;
    assign bus.mem_dataW  = go ? sel_wdata : 32'h0;
    assign bus.mem_funct3 = go ? sel_f3    : 3'b010;
    assign bus.mem_MemRW  = go && sel_we;

    // Only legal loads return memory data; stores and rejects return zero.
    assign rsp_data = (go && !sel_we) ? bus.mem_dataR : 32'h0;

    assign bus.p0_gnt       = sel0;
    assign bus.p1_gnt       = sel1;
    assign bus.p0_rsp_valid = rsp_valid[0];
    assign bus.p1_rsp_valid = rsp_valid[1];
    assign bus.p0_err       = err[0];
    assign bus.p1_err       = err[1];
    assign bus.p0_rdata     = rdata0;
    assign bus.p1_rdata     = rdata1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 1'b0;
            starve_cnt <= 4'd0;
            rsp_valid  <= 2'b00;
            err        <= 2'b00;
            rdata0     <= 32'h0;
            rdata1     <= 32'h0;
        end else begin
            active    <= 1'b1;
            rsp_valid <= {sel1, sel0};
            if (bus.p1_req && !sel1)
                starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
            else
                starve_cnt <= 4'd0;
            if (sel0) begin
                err[0] <= illegal;
                rdata0 <= rsp_data;
            end
            if (sel1) begin
                err[1] <= illegal;
                rdata1 <= rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-port expected-response queue.
// A monitor pops and compares whenever a port presents rsp_valid, and checks
// that every response lands exactly one cycle after its grant.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dmem_arbiter_if bus();

    dmem_arbiter #(.STARVE_LIMIT(4), .CHECK_ALIGN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- data_mem model: comb read, write on rising edge ----
    logic [31:0] mem [0:63];
    logic [31:0] rw;

    always_comb begin
        rw = mem[bus.mem_addr[7:2]] >> {bus.mem_addr[1:0], 3'b000};
        case (bus.mem_funct3)
            3'b000:  bus.mem_dataR = {{24{rw[7]}}, rw[7:0]};
            3'b001:  bus.mem_dataR = {{16{rw[15]}}, rw[15:0]};
            3'b100:  bus.mem_dataR = {24'h0, rw[7:0]};
            3'b101:  bus.mem_dataR = {16'h0, rw[15:0]};
            default: bus.mem_dataR = rw;
        endcase
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                          input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] m;
        case (f3[1:0])
            2'b00:   m = 32'hFF << {off, 3'b000};
            2'b01:   m = 32'hFFFF << {off[1], 4'b0000};
            default: m = 32'hFFFF_FFFF;
        endcase
        return (old & ~m) | ((d << {off, 3'b000}) & m);
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (bus.mem_MemRW) begin
            mem[bus.mem_addr[7:2]] <= merge(mem[bus.mem_addr[7:2]], bus.mem_addr[1:0],
                                            bus.mem_funct3, bus.mem_dataW);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [32:0] q0[$];
    logic [32:0] q1[$];

    task automatic pop_cmp(input int port, input logic err, input logic [31:0] rdata);
        logic [32:0] e;
        if (port == 0 && q0.size() == 0 || port == 1 && q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL p%0d_unexpected_rsp: got err=%b rdata=%h expected no response",
                     port, err, rdata);
        end else begin
            e = (port == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("p%0d_rsp_err", port), {31'h0, err}, {31'h0, e[32]});
            chk($sformatf("p%0d_rsp_rdata", port), rdata, e[31:0]);
        end
    endtask

    initial begin
        logic pg0, pg1;
        pg0 = 1'b0;
        pg1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pg0 = 1'b0;
                pg1 = 1'b0;
            end else begin
                if (bus.p0_rsp_valid || pg0)
                    chk("p0_rsp_timing", {31'h0, bus.p0_rsp_valid}, {31'h0, pg0});
                if (bus.p1_rsp_valid || pg1)
                    chk("p1_rsp_timing", {31'h0, bus.p1_rsp_valid}, {31'h0, pg1});
                if (bus.p0_rsp_valid) pop_cmp(0, bus.p0_err, bus.p0_rdata);
                if (bus.p1_rsp_valid) pop_cmp(1, bus.p1_err, bus.p1_rdata);
                pg0 = bus.p0_gnt;
                pg1 = bus.p1_gnt;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int port, input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_funct3 = f3;
            bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_funct3 = f3;
            bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    function automatic void expect_rsp(input int port, input logic err, input logic [31:0] rdata);
        if (port == 0) q0.push_back({err, rdata});
        else           q1.push_back({err, rdata});
    endfunction

    // Called just after a rising edge; returns just after the edge ending the grant.
    task automatic issue(input int port, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
        logic g;
        g = 1'b0;
        expect_rsp(port, exp_err, exp_rdata);
        drive(port, 1'b1, we, f3, addr, wdata);
        for (int n = 0; n < 50 && !g; n++) begin
            @(negedge clk);
            g = (port == 0) ? bus.p0_gnt : bus.p1_gnt;
        end
        if (!g) begin
            checks++;
            errors++;
            $display("FAIL p%0d_gnt_timeout: got no grant expected grant within 50 cycles", port);
        end
        @(posedge clk);
        #1;
        drive(port, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_rsp_valid"}, {30'h0, bus.p1_rsp_valid, bus.p0_rsp_valid}, 32'h0);
        chk({nm, "_err"},       {30'h0, bus.p1_err, bus.p0_err}, 32'h0);
        chk({nm, "_rdata0"},    bus.p0_rdata, 32'h0);
        chk({nm, "_rdata1"},    bus.p1_rdata, 32'h0);
        chk({nm, "_gnt"},       {30'h0, bus.p1_gnt, bus.p0_gnt}, 32'h0);
        chk({nm, "_memrw"},     {31'h0, bus.mem_MemRW}, 32'h0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

        // 1: reset state and first grant after release, with p0_req held
        drive(0, 1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        expect_rsp(0, 1'b0, 32'h0);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        clr = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_no_gnt_first_cycle", {31'h0, bus.p0_gnt}, 32'h0);
        @(negedge clk);
        chk("t1_gnt_second_cycle", {31'h0, bus.p0_gnt}, 32'h1);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

        // 2: sw, sb into it, lw back (back-to-back grants)
        issue(0, 1'b1, 3'b010, 32'h08, 32'h1234_5678, 1'b0, 32'h0);
        issue(0, 1'b1, 3'b000, 32'h09, 32'h0000_00AB, 1'b0, 32'h0);
        issue(0, 1'b0, 3'b010, 32'h08, 32'h0,         1'b0, 32'h1234_AB78);

        // 3: halfword store/loads, then a misaligned word store is rejected
        issue(0, 1'b1, 3'b001, 32'h0A, 32'h0000_FACE, 1'b0, 32'h0);
        issue(0, 1'b0, 3'b001, 32'h0A, 32'h0,         1'b0, 32'hFFFF_FACE);
        issue(0, 1'b0, 3'b101, 32'h0A, 32'h0,         1'b0, 32'h0000_FACE);
        expect_rsp(0, 1'b1, 32'h0);
        drive(0, 1'b1, 1'b1, 3'b010, 32'h0A, 32'h9999_9999);
        @(negedge clk);
        chk("t3_misaligned_gnt", {31'h0, bus.p0_gnt}, 32'h1);
        chk("t3_misaligned_memrw", {31'h0, bus.mem_MemRW}, 32'h0);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        issue(0, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hFACE_AB78);
        // illegal funct3 on a load and unsigned code used as a store
        issue(0, 1'b0, 3'b011, 32'h08, 32'h0, 1'b1, 32'h0);
        issue(0, 1'b1, 3'b100, 32'h08, 32'h0, 1'b1, 32'h0);

        // 4: simultaneous requests, one cycle each
        expect_rsp(0, 1'b0, 32'hFACE_AB78);
        expect_rsp(1, 1'b0, 32'h0);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        drive(1, 1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t4_first_gnt", {30'h0, bus.p1_gnt, bus.p0_gnt}, 32'h1);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_second_gnt", {30'h0, bus.p1_gnt, bus.p0_gnt}, 32'h2);
        @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        // read-after-write on consecutive cycles
        issue(0, 1'b1, 3'b010, 32'h14, 32'h0BAD_F00D, 1'b0, 32'h0);
        issue(0, 1'b0, 3'b010, 32'h14, 32'h0,         1'b0, 32'h0BAD_F00D);

        // 5: starvation: p1 forced through on its fifth request cycle
        for (int i = 0; i < 5; i++) expect_rsp(0, 1'b0, 32'hFACE_AB78);
        expect_rsp(1, 1'b0, 32'hDEAD_BEEF);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("t5_gnt_cycle%0d", c), {30'h0, bus.p1_gnt, bus.p0_gnt},
                (c == 4) ? 32'h2 : 32'h1);
            if (c == 4) begin
                @(posedge clk);
                #1 drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
            end
        end
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

        // 6: reset asserted inside a p1 store grant cycle
        drive(1, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0000_0055);
        @(negedge clk);
        chk("t6_gnt_before_reset", {31'h0, bus.p1_gnt}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("t6_gnt_in_reset", {30'h0, bus.p1_gnt, bus.p0_gnt}, 32'h0);
        chk("t6_memrw_in_reset", {31'h0, bus.mem_MemRW}, 32'h0);
        @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        chk_reset_outputs("t6_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 1'b1, 3'b010, 32'h10, 32'h5566_7788, 1'b0, 32'h0);
        issue(1, 1'b0, 3'b010, 32'h10, 32'h0,         1'b0, 32'h5566_7788);
        issue(1, 1'b0, 3'b000, 32'h12, 32'h0,         1'b0, 32'h0000_0066);

        repeat (3) @(posedge clk);
        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
